// File: rtl/riscv_mem_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, bus owner and
// default bus widths.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks for the arbiter's memory bus and its response pulses; bound
// to the same nets as the arbiter ports.
module mem_port_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic bus_req,
  input logic bus_gnt,
  input logic bus_rvalid,
  input logic if_rvalid,
  input logic mem_rvalid
);

  // A response may only follow a granted request, never overlap one still pending.
  a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (rst)
    !(bus_req && bus_rvalid));

  // A request is never withdrawn before it is granted.
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (bus_req && !bus_gnt) |=> bus_req);

  // Only one requester completes per cycle.
  a_one_completion: assert property (@(posedge clk) disable iff (rst)
    !(if_rvalid && mem_rvalid));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory bus between instruction fetch
// and load/store, with data priority, pipeline stalls and redirect kill.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  output logic                stall_if,
  input  logic                flush_if,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rvalid,
  output logic                stall_mem,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t          state_r, state_nx_s;
  owner_t              owner_r, owner_nx_s;
  logic                kill_r, kill_nx_s;
  logic                load_data_s, load_fetch_s;
  logic                fetch_flush_s;
  logic                if_rvalid_s, mem_rvalid_s;
  logic                bus_req_r, bus_we_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_wdata_r;
  logic [STRB_W-1:0]   bus_wstrb_r;

  // A redirect only matters while the bus is working on a fetch.
  assign fetch_flush_s = flush_if && (owner_r == FETCH);

  // Next state, owner, kill flag and payload-load decisions
  always_comb begin
    state_nx_s   = state_r;
    owner_nx_s   = owner_r;
    kill_nx_s    = kill_r;
    load_data_s  = 1'b0;
    load_fetch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          load_data_s = 1'b1;
          state_nx_s  = REQ;
          owner_nx_s  = DATA;
        end else if (if_req && !flush_if) begin
          load_fetch_s = 1'b1;
          state_nx_s   = REQ;
          owner_nx_s   = FETCH;
        end else begin
          state_nx_s = IDLE;
          owner_nx_s = NONE;
        end
      end
      REQ: begin
        // Killing a fetch never withdraws the request; the response is dropped later.
        if (fetch_flush_s) begin
          kill_nx_s = 1'b1;
        end else begin
          kill_nx_s = kill_r;
        end
        if (bus_gnt) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = REQ;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          kill_nx_s = 1'b0;
          // Re-arbitrate excluding the owner that is completing right now.
          if ((owner_r == FETCH) && mem_req) begin
            load_data_s = 1'b1;
            state_nx_s  = REQ;
            owner_nx_s  = DATA;
          end else if ((owner_r == DATA) && if_req && !flush_if) begin
            load_fetch_s = 1'b1;
            state_nx_s   = REQ;
            owner_nx_s   = FETCH;
          end else begin
            state_nx_s = IDLE;
            owner_nx_s = NONE;
          end
        end else if (fetch_flush_s) begin
          kill_nx_s = 1'b1;
        end else begin
          kill_nx_s = kill_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        owner_nx_s = NONE;
        kill_nx_s  = 1'b0;
      end
    endcase
  end

  assign if_rvalid_s  = (state_r == RESP) && (owner_r == FETCH) && bus_rvalid
                        && !kill_r && !flush_if;
  assign mem_rvalid_s = (state_r == RESP) && (owner_r == DATA) && bus_rvalid;

  assign if_rvalid  = if_rvalid_s;
  assign mem_rvalid = mem_rvalid_s;
  assign if_rdata   = bus_rdata;
  assign mem_rdata  = bus_rdata;
  // While a load/store owns the bus the fetch cannot be served, so IF holds too.
  assign stall_if   = (if_req && !if_rvalid_s) || (owner_r == DATA);
  assign stall_mem  = mem_req && !mem_rvalid_s;

  // FSM state, bus owner and kill flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= NONE;
      kill_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      owner_r <= owner_nx_s;
      kill_r  <= kill_nx_s;
    end
  end

  // Registered bus request; the payload only changes when a new winner is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      bus_wstrb_r <= '0;
    end else begin
      bus_req_r <= (state_nx_s == REQ);
      if (load_data_s) begin
        bus_we_r    <= mem_we;
        bus_addr_r  <= mem_addr;
        bus_wdata_r <= mem_wdata;
        bus_wstrb_r <= mem_wstrb;
      end else if (load_fetch_s) begin
        bus_we_r    <= 1'b0;
        bus_addr_r  <= if_addr;
        bus_wdata_r <= '0;
        bus_wstrb_r <= '0;
      end else begin
        bus_we_r    <= bus_we_r;
        bus_addr_r  <= bus_addr_r;
        bus_wdata_r <= bus_wdata_r;
        bus_wstrb_r <= bus_wstrb_r;
      end
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_wstrb = bus_wstrb_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized IF/MEM/bus traffic phase for
// mem_port_arbiter, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush_if, if_rvalid, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_rvalid, stall_mem;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .stall_if(stall_if), .flush_if(flush_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  mem_port_arbiter_chk chk_i (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .if_rvalid(if_rvalid), .mem_rvalid(mem_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    end
    return r;
  endfunction

  // Randomized-phase state: requesters, open bus transaction, responder, memories.
  logic        f_act, m_act, m_issued, m_we;
  logic [31:0] f_pc, m_addr, m_wdata;
  logic [3:0]  m_strb;
  int          f_age, m_age;
  logic        t_open, t_data, t_killed, t_granted;
  logic        r_pend, r_we;
  int          r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;
  logic        p_mwait, p_felig;
  logic [31:0] p_pc;
  logic        exp_ifv, exp_memv, drain;
  logic [31:0] old_w;
  logic [31:0] bus_mem [int];
  logic [31:0] ref_mem [int];

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; flush_if = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

    // Reset values
    cyc(); cyc(); settle();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);

    // Fetch only, minimum latency
    cyc(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; settle();
    chk("t1_stall_if_c0", 32'(stall_if), 32'd1);
    chk("t1_bus_req_c0", 32'(bus_req), 32'd0);
    cyc(); bus_gnt = 1'b1; settle();
    chk("t1_bus_req_c1", 32'(bus_req), 32'd1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_stall_if_c1", 32'(stall_if), 32'd1);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0001; settle();
    chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hCAFE_0001);
    chk("t1_stall_if_c2", 32'(stall_if), 32'd0);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b0; settle();
    chk("t1_if_rvalid_off", 32'(if_rvalid), 32'd0);

    // Store and fetch together: data first, fetch issued straight from RESP
    cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
    mem_wstrb = 4'hF; if_req = 1'b1; if_addr = 32'h104; settle();
    chk("t2_stall_if_c0", 32'(stall_if), 32'd1);
    chk("t2_stall_mem_c0", 32'(stall_mem), 32'd1);
    cyc(); bus_gnt = 1'b1; settle();
    chk("t2_bus_we", 32'(bus_we), 32'd1);
    chk("t2_bus_addr", bus_addr, 32'h2000);
    chk("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("t2_bus_wstrb", 32'(bus_wstrb), 32'hF);
    chk("t2_stall_if_c1", 32'(stall_if), 32'd1);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; settle();
    chk("t2_mem_rvalid", 32'(mem_rvalid), 32'd1);
    chk("t2_if_rvalid_c2", 32'(if_rvalid), 32'd0);
    chk("t2_stall_mem_c2", 32'(stall_mem), 32'd0);
    chk("t2_stall_if_c2", 32'(stall_if), 32'd1);
    cyc(); mem_req = 1'b0; mem_we = 1'b0; bus_rvalid = 1'b0; bus_gnt = 1'b1; settle();
    chk("t2_fetch_req_no_idle", 32'(bus_req), 32'd1);
    chk("t2_fetch_addr", bus_addr, 32'h104);
    chk("t2_fetch_we", 32'(bus_we), 32'd0);
    chk("t2_fetch_wstrb", 32'(bus_wstrb), 32'h0);
    chk("t2_stall_if_c3", 32'(stall_if), 32'd1);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0104; settle();
    chk("t2_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t2_stall_if_c4", 32'(stall_if), 32'd0);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b0;

    // Flush while the fetch is in RESP, then fetch the new PC
    cyc(); if_req = 1'b1; if_addr = 32'h300;
    cyc(); bus_gnt = 1'b1;
    cyc(); bus_gnt = 1'b0; flush_if = 1'b1; if_addr = 32'h200; settle();
    chk("t3_if_rvalid_flush", 32'(if_rvalid), 32'd0);
    cyc(); flush_if = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0300; settle();
    chk("t3_killed_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t3_stall_if_killed", 32'(stall_if), 32'd1);
    cyc(); bus_rvalid = 1'b0; settle();
    chk("t3_idle_bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_gnt = 1'b1; settle();
    chk("t3_new_bus_addr", bus_addr, 32'h200);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0200; settle();
    chk("t3_new_if_rvalid", 32'(if_rvalid), 32'd1);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b0;

    // Grant delayed 3 cycles, flush in the first request cycle
    cyc(); if_req = 1'b1; if_addr = 32'h400;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      flush_if = (i == 1);
      if (i == 1) if_addr = 32'h500;
      bus_gnt = (i == 4);
      settle();
      chk($sformatf("t4_bus_req_c%0d", i), 32'(bus_req), 32'd1);
      chk($sformatf("t4_bus_addr_c%0d", i), bus_addr, 32'h400);
    end
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_0400; settle();
    chk("t4_dropped_if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); bus_rvalid = 1'b0;
    cyc(); bus_gnt = 1'b1; settle();
    chk("t4_refetch_addr", bus_addr, 32'h500);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; settle();
    chk("t4_refetch_if_rvalid", 32'(if_rvalid), 32'd1);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b0;

    // Reset while in RESP, pending fetch re-issued afterwards
    cyc(); if_req = 1'b1; if_addr = 32'h600;
    cyc(); bus_gnt = 1'b1;
    cyc(); bus_gnt = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0; settle();
    chk("t5_rst_bus_req", 32'(bus_req), 32'd0);
    chk("t5_rst_bus_addr", bus_addr, 32'h0);
    chk("t5_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    cyc(); bus_gnt = 1'b1; settle();
    chk("t5_reissue_req", 32'(bus_req), 32'd1);
    chk("t5_reissue_addr", bus_addr, 32'h600);
    cyc(); bus_gnt = 1'b0; bus_rvalid = 1'b1; settle();
    chk("t5_if_rvalid", 32'(if_rvalid), 32'd1);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b0;

    // Load with a 5-cycle response latency
    cyc(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; settle();
    chk("t6_stall_mem_c0", 32'(stall_mem), 32'd1);
    cyc(); bus_gnt = 1'b1; settle();
    chk("t6_stall_mem_c1", 32'(stall_mem), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      cyc(); bus_gnt = 1'b0; settle();
      chk($sformatf("t6_stall_mem_c%0d", i), 32'(stall_mem), 32'd1);
      chk($sformatf("t6_mem_rvalid_c%0d", i), 32'(mem_rvalid), 32'd0);
    end
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; settle();
    chk("t6_mem_rvalid", 32'(mem_rvalid), 32'd1);
    chk("t6_mem_rdata", mem_rdata, 32'h1234_5678);
    chk("t6_stall_mem_c6", 32'(stall_mem), 32'd0);
    cyc(); mem_req = 1'b0; bus_rvalid = 1'b0; settle();
    chk("t6_mem_rvalid_off", 32'(mem_rvalid), 32'd0);

    // Randomized traffic against a transaction-level model
    f_act = 1'b0; m_act = 1'b0; m_issued = 1'b0; m_we = 1'b0;
    f_pc = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_strb = 4'h0; f_age = 0; m_age = 0;
    t_open = 1'b0; t_data = 1'b0; t_killed = 1'b0; t_granted = 1'b0;
    r_pend = 1'b0; r_we = 1'b0; r_cnt = 0; r_addr = 32'h0; r_wdata = 32'h0; r_strb = 4'h0;
    p_mwait = 1'b0; p_felig = 1'b0; p_pc = 32'h0;
    for (int cy = 0; cy < 900; cy++) begin
      cyc();
      drain = (cy >= 750);
      flush_if = 1'b0;
      if (!drain && $urandom_range(0, 15) == 0) begin
        flush_if = 1'b1; f_act = 1'b1; f_pc = 32'(4 * $urandom_range(0, 255)); f_age = 0;
      end else if (!f_act && !drain && $urandom_range(0, 2) == 0) begin
        f_act = 1'b1; f_pc = 32'(4 * $urandom_range(0, 255)); f_age = 0;
      end
      if_req = f_act; if_addr = f_pc;
      if (!m_act && !drain && $urandom_range(0, 3) == 0) begin
        m_act = 1'b1; m_issued = 1'b0; m_we = 1'($urandom_range(0, 1));
        m_addr = 32'h1000 + 32'(4 * $urandom_range(0, 7));
        m_wdata = $urandom; m_strb = 4'($urandom_range(1, 15)); m_age = 0;
      end
      mem_req = m_act; mem_we = m_we; mem_addr = m_addr; mem_wdata = m_wdata; mem_wstrb = m_strb;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (r_pend) begin
        if (r_cnt == 0) begin
          bus_rvalid = 1'b1; r_pend = 1'b0;
          old_w = bus_mem.exists(int'(r_addr)) ? bus_mem[int'(r_addr)] : init_word(r_addr);
          if (r_we) bus_mem[int'(r_addr)] = merge(old_w, r_wdata, r_strb);
          else bus_rdata = old_w;
        end else begin
          r_cnt--;
        end
      end else if (bus_req && $urandom_range(0, 1) == 1) begin
        bus_gnt = 1'b1; r_pend = 1'b1; r_cnt = $urandom_range(0, 4);
        r_we = bus_we; r_addr = bus_addr; r_wdata = bus_wdata; r_strb = bus_wstrb;
      end
      settle();
      if (bus_req && !t_open) begin
        chk("rnd_start_allowed", 32'(p_mwait || p_felig), 32'd1);
        chk("rnd_winner_is_data", 32'(bus_addr >= 32'h1000), 32'(p_mwait));
        t_open = 1'b1; t_data = p_mwait; t_killed = 1'b0; t_granted = 1'b0;
        if (p_mwait) begin
          chk("rnd_data_we", 32'(bus_we), 32'(m_we));
          chk("rnd_data_addr", bus_addr, m_addr);
          chk("rnd_data_wdata", bus_wdata, m_wdata);
          chk("rnd_data_wstrb", 32'(bus_wstrb), 32'(m_strb));
          m_issued = 1'b1;
        end else begin
          chk("rnd_fetch_addr", bus_addr, p_pc);
          chk("rnd_fetch_we", 32'(bus_we), 32'd0);
        end
      end
      if (t_open && t_granted) chk("rnd_req_dropped_after_gnt", 32'(bus_req), 32'd0);
      if (t_open && !t_data && flush_if) t_killed = 1'b1;
      exp_ifv  = t_open && !t_data && bus_rvalid && !t_killed;
      exp_memv = t_open && t_data && bus_rvalid;
      chk("rnd_if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
      chk("rnd_mem_rvalid", 32'(mem_rvalid), 32'(exp_memv));
      chk("rnd_stall_if", 32'(stall_if), 32'((if_req && !exp_ifv) || (t_open && t_data)));
      chk("rnd_stall_mem", 32'(stall_mem), 32'(mem_req && !exp_memv));
      p_mwait = mem_req && !m_issued;
      p_felig = if_req && !flush_if && !(bus_rvalid && t_open && !t_data);
      p_pc    = if_addr;
      if (exp_memv) begin
        old_w = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : init_word(m_addr);
        if (m_we) ref_mem[int'(m_addr)] = merge(old_w, m_wdata, m_strb);
        else chk("rnd_load_data", mem_rdata, old_w);
        chk("rnd_mem_latency", 32'(m_age <= 60), 32'd1);
        m_act = 1'b0;
      end
      if (exp_ifv) begin
        chk("rnd_fetch_latency", 32'(f_age <= 60), 32'd1);
        f_act = 1'b0;
      end
      if (bus_gnt) t_granted = 1'b1;
      if (bus_rvalid) t_open = 1'b0;
      if (f_act) f_age++;
      if (m_act) m_age++;
    end
    chk("drain_mem_done", 32'(m_act), 32'd0);
    chk("drain_fetch_done", 32'(f_act), 32'd0);
    chk("drain_bus_idle", 32'(t_open), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
